// File: rtl/self_destruct_sequencer.sv
// Self-destruct countdown controller: arm qualification, countdown with hold/resume,
// timed abort and a latched detonation state. It drives the LED display code directly.
module self_destruct_sequencer #(
  parameter int COUNT_MAX = 10,
  parameter int ARM_TICKS = 3,
  parameter int HOLD_MAX  = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_10ms,
  input  logic       tick_1s,
  input  logic       in_combat,
  input  logic       in_danger,
  input  logic       damaged,
  input  logic       immobilized,
  input  logic       abort_req,
  output logic [3:0] leds,
  output logic [2:0] state_o,
  output logic       detonate
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMING    = 3'd1,
    S_COUNTING  = 3'd2,
    S_HOLD      = 3'd3,
    S_ABORTED   = 3'd4,
    S_DETONATED = 3'd5
  } state_t;

  localparam logic [3:0] ARM_LAST  = 4'(ARM_TICKS - 1);
  localparam logic [3:0] CNT_LAST  = 4'(COUNT_MAX - 1);
  localparam logic [3:0] CNT_FULL  = 4'(COUNT_MAX);
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] arm_cnt_q, arm_cnt_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] leds_q, leds_d;
  logic       detonate_q, detonate_d;
  logic       critical;
  logic       kill;

  assign critical = (in_danger & damaged) | (in_danger & immobilized) | (damaged & immobilized);
  // Abort request and loss of combat enable are handled identically everywhere.
  assign kill     = abort_req | ~in_combat;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arm_cnt_d  = arm_cnt_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d      = 4'd0;
        arm_cnt_d  = 4'd0;
        hold_cnt_d = 4'd0;
        if (!kill && critical) state_d = S_ARMING;
      end
      S_ARMING: begin
        cnt_d = 4'd0;
        if (kill || !critical) begin
          state_d   = S_IDLE;
          arm_cnt_d = 4'd0;
        end else if (tick_10ms) begin
          if (arm_cnt_q == ARM_LAST) begin
            state_d   = S_COUNTING;
            arm_cnt_d = 4'd0;
          end else begin
            arm_cnt_d = arm_cnt_q + 4'd1;
          end
        end
      end
      S_COUNTING: begin
        if (kill) begin
          state_d = S_ABORTED;
          cnt_d   = 4'd0;
        end else if (!critical) begin
          // Entering HOLD swallows any tick_1s arriving on the same edge.
          state_d    = S_HOLD;
          hold_cnt_d = 4'd0;
        end else if (tick_1s) begin
          if (cnt_q == CNT_LAST) begin
            state_d = S_DETONATED;
            cnt_d   = CNT_FULL;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_HOLD: begin
        if (kill) begin
          state_d    = S_ABORTED;
          cnt_d      = 4'd0;
          hold_cnt_d = 4'd0;
        end else if (critical) begin
          state_d    = S_COUNTING;
          hold_cnt_d = 4'd0;
        end else if (tick_1s) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d    = S_ABORTED;
            cnt_d      = 4'd0;
            hold_cnt_d = 4'd0;
          end else begin
            hold_cnt_d = hold_cnt_q + 4'd1;
          end
        end
      end
      S_ABORTED: begin
        cnt_d = 4'd0;
        if (tick_1s && !critical) state_d = S_IDLE;
      end
      S_DETONATED: begin
      end
      default: begin
        state_d    = S_IDLE;
        cnt_d      = 4'd0;
        arm_cnt_d  = 4'd0;
        hold_cnt_d = 4'd0;
      end
    endcase
  end

  // Display and detonate are derived from the next state so they align with state_o.
  always_comb begin
    leds_d = 4'h0;
    case (state_d)
      S_COUNTING, S_HOLD: leds_d = cnt_d;
      S_ABORTED:          leds_d = 4'hE;
      S_DETONATED:        leds_d = 4'hF;
      default:            leds_d = 4'h0;
    endcase
    detonate_d = (state_d == S_DETONATED);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      arm_cnt_q  <= 4'd0;
      hold_cnt_q <= 4'd0;
      leds_q     <= 4'h0;
      detonate_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arm_cnt_q  <= arm_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      leds_q     <= leds_d;
      detonate_q <= detonate_d;
    end
  end

  assign leds     = leds_q;
  assign state_o  = state_q;
  assign detonate = detonate_q;

endmodule

// File: tb/tb_self_destruct_sequencer.sv
// Bench for self_destruct_sequencer: directed scenarios plus random stimulus,
// all checked cycle by cycle against a behavioural reference model.
module tb_self_destruct_sequencer;

  localparam int COUNT_MAX = 10;
  localparam int ARM_TICKS = 3;
  localparam int HOLD_MAX  = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_10ms = 1'b0;
  logic       tick_1s = 1'b0;
  logic       in_combat = 1'b0;
  logic       in_danger = 1'b0;
  logic       damaged = 1'b0;
  logic       immobilized = 1'b0;
  logic       abort_req = 1'b0;
  logic [3:0] leds;
  logic [2:0] state_o;
  logic       detonate;

  int total = 0;
  int bad   = 0;

  // Reference model: phase named by its displayed code plus plain counters.
  int m_phase = 0;
  int m_secs  = 0;
  int m_arms  = 0;
  int m_held  = 0;

  self_destruct_sequencer #(
    .COUNT_MAX(COUNT_MAX),
    .ARM_TICKS(ARM_TICKS),
    .HOLD_MAX (HOLD_MAX)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tick_10ms  (tick_10ms),
    .tick_1s    (tick_1s),
    .in_combat  (in_combat),
    .in_danger  (in_danger),
    .damaged    (damaged),
    .immobilized(immobilized),
    .abort_req  (abort_req),
    .leds       (leds),
    .state_o    (state_o),
    .detonate   (detonate)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_leds();
    case (m_phase)
      2, 3:    return m_secs;
      4:       return 14;
      5:       return 15;
      default: return 0;
    endcase
  endfunction

  task automatic model_step();
    int  votes;
    bit  crit;
    bit  quit;
    votes = int'(in_danger) + int'(damaged) + int'(immobilized);
    crit  = (votes >= 2);
    quit  = abort_req || !in_combat;
    if (!reset) begin
      m_phase = 0; m_secs = 0; m_arms = 0; m_held = 0;
    end else begin
      case (m_phase)
        0: if (!quit && crit) begin m_phase = 1; m_arms = 0; end
        1: begin
          if (quit || !crit) begin
            m_phase = 0; m_arms = 0;
          end else if (tick_10ms) begin
            m_arms += 1;
            if (m_arms == ARM_TICKS) begin m_phase = 2; m_secs = 0; end
          end
        end
        2: begin
          if (quit) begin
            m_phase = 4; m_secs = 0;
          end else if (!crit) begin
            m_phase = 3; m_held = 0;
          end else if (tick_1s) begin
            m_secs += 1;
            if (m_secs == COUNT_MAX) m_phase = 5;
          end
        end
        3: begin
          if (quit) begin
            m_phase = 4; m_secs = 0;
          end else if (crit) begin
            m_phase = 2; m_held = 0;
          end else if (tick_1s) begin
            m_held += 1;
            if (m_held == HOLD_MAX) begin m_phase = 4; m_secs = 0; end
          end
        end
        4: if (tick_1s && !crit) m_phase = 0;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input bit t10, input bit t1, input bit ab);
    tick_10ms = t10;
    tick_1s   = t1;
    abort_req = ab;
    model_step();
    @(posedge clk);
    #1;
    chk("state", 8'(state_o), 8'(m_phase));
    chk("leds", 8'(leds), 8'(exp_leds()));
    chk("detonate", 8'(detonate), 8'(m_phase == 5));
    tick_10ms = 1'b0;
    tick_1s   = 1'b0;
    abort_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(0, 0, 0);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    do_reset();
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_leds", 8'(leds), 8'd0);
    chk("rst_det", 8'(detonate), 8'd0);

    // Full countdown to detonation.
    in_combat = 1; in_danger = 1; damaged = 1;
    cyc(0, 0, 0);
    chk("t1_arming", 8'(state_o), 8'd1);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    chk("t1_counting", 8'(state_o), 8'd2);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0);
      if (i < 10) chk("t1_walk", 8'(leds), 8'(i));
    end
    chk("t1_det_state", 8'(state_o), 8'd5);
    chk("t1_det_leds", 8'(leds), 8'hF);
    chk("t1_det_flag", 8'(detonate), 8'd1);

    // Detonation is terminal; only reset exits.
    in_combat = 0;
    cyc(0, 1, 1);
    cyc(1, 0, 0);
    chk("t6_latched", 8'(state_o), 8'd5);
    chk("t6_latched_leds", 8'(leds), 8'hF);
    do_reset();
    chk("t6_rst_state", 8'(state_o), 8'd0);
    chk("t6_rst_det", 8'(detonate), 8'd0);

    // Arm glitch rejection.
    in_combat = 1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    damaged = 0;
    cyc(0, 0, 0);
    chk("t2_glitch", 8'(state_o), 8'd0);
    damaged = 1;
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("t2_still_arming", 8'(state_o), 8'd1);
    cyc(1, 0, 0);
    chk("t2_counting", 8'(state_o), 8'd2);

    // Hold and resume; critical drop coincident with a 1 s tick.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0);
    damaged = 0;
    cyc(0, 1, 0);
    chk("t5_hold_state", 8'(state_o), 8'd3);
    chk("t5_hold_leds", 8'(leds), 8'd4);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("t3_frozen", 8'(leds), 8'd4);
    damaged = 1;
    cyc(0, 1, 0);
    chk("t3_resume", 8'(state_o), 8'd2);
    chk("t3_resume_leds", 8'(leds), 8'd4);
    cyc(0, 1, 0);
    chk("t3_next", 8'(leds), 8'd5);

    // Hold timeout then release.
    damaged = 0;
    cyc(0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    chk("t4_abort_state", 8'(state_o), 8'd4);
    chk("t4_abort_leds", 8'(leds), 8'hE);
    cyc(0, 1, 0);
    chk("t4_idle", 8'(state_o), 8'd0);

    // Abort coincident with the final tick.
    damaged = 1;
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 0);
    chk("t5_cnt9", 8'(leds), 8'd9);
    cyc(0, 1, 1);
    chk("t5_abort_win", 8'(state_o), 8'd4);
    chk("t5_no_det", 8'(detonate), 8'd0);
    cyc(0, 1, 0);
    chk("t5_abort_stays", 8'(state_o), 8'd4);
    damaged = 0;
    cyc(0, 1, 0);

    // Reset in the middle of a countdown.
    damaged = 1;
    cyc(0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    do_reset();
    chk("t6_mid_rst", 8'(state_o), 8'd0);
    chk("t6_mid_rst_leds", 8'(leds), 8'd0);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      bit t10, t1, ab;
      reset = ($urandom_range(0, 299) != 0);
      in_combat = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 14) == 0) in_danger = ~in_danger;
      if ($urandom_range(0, 14) == 0) damaged = ~damaged;
      if ($urandom_range(0, 14) == 0) immobilized = ~immobilized;
      t10 = ($urandom_range(0, 2) == 0);
      t1  = ($urandom_range(0, 4) == 0);
      ab  = ($urandom_range(0, 79) == 0);
      cyc(t10, t1, ab);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
